axis_byte_unpacker: RTL and testbench
=====================================

# axis_byte_unpacker

Upstream feeder for the compressor's 2-entry input FIFO. Accepts a 32-bit AXI-stream (tdata/tkeep/tlast) from the host side and emits one byte per transfer as a 9-bit word: {end-of-stream flag, byte}. A one-byte lookahead register marks the final byte of each stream with bit 8 set, including streams whose tlast beat carries no valid lanes.

## Interface
- Parameters: none.
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- i_tvalid  in  1  input beat valid
- i_tready  out  1  input beat accepted when i_tvalid & i_tready
- i_tdata  in  32  lane k = i_tdata[8k+7:8k], lane 0 is first in stream order
- i_tkeep  in  4  lane k valid when i_tkeep[k]=1; sparse patterns allowed
- i_tlast  in  1  beat is the last of the stream
- o_rdy  in  1  downstream can accept (FIFO not full)
- o_en  out  1  o_data valid; transfer when o_en & o_rdy
- o_data  out  9  [8] = last byte of stream, [7:0] = byte

## Operation
- State: beat buffer (data 32, remaining mask 4, last 1, valid 1); pending byte (8, valid); output register (o_data, o_en).
- i_tready = rstn & ~beat_valid (no combinational path from o_rdy or i_tvalid). Accepted beat loads data, mask = i_tkeep, last = i_tlast.
- out_free = ~o_en | o_rdy. has_byte = beat_valid & (mask != 0). lo = lowest set mask bit.
- Per-cycle action, first match wins:
  1. beat_valid & mask==0 & ~last: discard beat (tkeep=0 non-last beat).
  2. pending_valid & has_byte & out_free: output <= {0,pending}, o_en<=1; pending <= lane lo; clear mask bit lo.
  3. pending_valid & beat_valid & mask==0 & last & out_free: output <= {1,pending}, o_en<=1; pending invalid; discard beat.
  4. ~pending_valid & has_byte: pending <= lane lo, pending_valid<=1; clear mask bit lo (does not need out_free).
  5. ~pending_valid & beat_valid & mask==0 & last: discard beat; no output (empty stream dropped silently).
- In actions 2/4, if the cleared bit empties the mask and last=0, the beat is discarded in the same cycle; if last=1 the beat stays for action 3.
- Output register: if no load this cycle and o_en & o_rdy, o_en<=0. o_data holds while o_en & ~o_rdy.
- Lanes emitted in ascending lane order; lanes with tkeep=0 skipped; byte order preserved across beats.
- Exactly one byte per stream carries bit 8 = 1, always the last kept byte of the stream.

## Timing
- Reset (rstn=0 at a rising edge): beat, pending, output cleared; o_en=0, o_data=0, i_tready=0 while rstn=0, i_tready=1 first cycle after release. Reset mid-stream discards all held bytes, no end flag emitted.
- Latency: beat accepted at edge T0 → pending filled T1 → o_en high after T2 (first byte of stream, provided a second byte or tlast is already present).
- Single-lane tlast beat into idle block: o_en=1, o_data={1,byte} after T2.
- Throughput with o_rdy=1 and full 4-lane beats: 4 bytes per 5 cycles (beat reload bubble).
- o_rdy low: output holds; pending and beat buffer hold; i_tready stays low once beat buffer is occupied.

## Test plan
- Single beat tdata=0x44332211, tkeep=4'hF, tlast=1, o_rdy=1 → o_data sequence 0x011, 0x022, 0x033, 0x144; then o_en=0.
- Two beats 0x04030201/keep F/last 0 then 0x000000AA/keep 1/last 1 → 0x001,0x002,0x003,0x004,0x1AA.
- Sparse: tdata=0xDDCCBBAA, tkeep=4'b1010, tlast=1 → 0x0BB then 0x1DD.
- Terminator-only beat: 0x11223344/keep F/last 0 then keep 0/last 1 → 0x044,0x033,0x022,0x111; separately lone keep-0 tlast beat into idle block → no output, i_tready returns high.
- Backpressure: full beat last=1, o_rdy toggles 1,0,0,1,... → o_data stable while o_en & ~o_rdy, no byte lost/duplicated, final 0x1xx once.
- Reset mid-stream after two bytes emitted → o_en=0, i_tready=0 during reset; next stream 0x000000EE/keep 1/last 1 yields only 0x1EE.

Source files
------------

// File: rtl/axis_byte_unpacker.sv
// Splits a 32-bit AXI-stream into one byte per transfer, tagging the final byte of each
// stream with bit 8 by holding every byte back one step until the next one (or tlast) is known.
module axis_byte_unpacker (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_tvalid,
    output logic        i_tready,
    input  logic [31:0] i_tdata,
    input  logic [3:0]  i_tkeep,
    input  logic        i_tlast,
    input  logic        o_rdy,
    output logic        o_en,
    output logic [8:0]  o_data
);

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        logic [1:0] l;
        if (m[0])      l = 2'd0;
        else if (m[1]) l = 2'd1;
        else if (m[2]) l = 2'd2;
        else           l = 2'd3;
        return l;
    endfunction

    logic [31:0] beat_data_q, beat_data_d;
    logic [3:0]  beat_mask_q, beat_mask_d;
    logic        beat_last_q, beat_last_d;
    logic        beat_vld_q,  beat_vld_d;
    logic [7:0]  pend_q,      pend_d;
    logic        pend_vld_q,  pend_vld_d;
    logic [8:0]  o_data_q,    o_data_d;
    logic        o_en_q,      o_en_d;

    logic        out_free;
    logic        mask_zero;
    logic        has_byte;
    logic [1:0]  lo;
    logic [7:0]  lo_byte;
    logic [3:0]  mask_cleared;
    logic        load_out;

    assign i_tready     = rstn & ~beat_vld_q;
    assign o_en         = o_en_q;
    assign o_data       = o_data_q;

    assign out_free     = ~o_en_q | o_rdy;
    assign mask_zero    = (beat_mask_q == 4'd0);
    assign has_byte     = beat_vld_q & ~mask_zero;
    assign lo           = lowest_lane(beat_mask_q);
    assign lo_byte      = beat_data_q[{lo, 3'b000} +: 8];
    assign mask_cleared = beat_mask_q & ~(4'b0001 << lo);

    always_comb begin
        beat_data_d = beat_data_q;
        beat_mask_d = beat_mask_q;
        beat_last_d = beat_last_q;
        beat_vld_d  = beat_vld_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        o_data_d    = o_data_q;
        o_en_d      = o_en_q;
        load_out    = 1'b0;

        if (beat_vld_q && mask_zero && !beat_last_q) begin
            beat_vld_d = 1'b0;
        end else if (pend_vld_q && has_byte && out_free) begin
            // Another byte follows, so the pending one cannot be the stream end
            o_data_d    = {1'b0, pend_q};
            load_out    = 1'b1;
            pend_d      = lo_byte;
            beat_mask_d = mask_cleared;
            if ((mask_cleared == 4'd0) && !beat_last_q) begin
                beat_vld_d = 1'b0;
            end
        end else if (pend_vld_q && beat_vld_q && mask_zero && beat_last_q && out_free) begin
            o_data_d   = {1'b1, pend_q};
            load_out   = 1'b1;
            pend_vld_d = 1'b0;
            beat_vld_d = 1'b0;
        end else if (!pend_vld_q && has_byte) begin
            pend_d      = lo_byte;
            pend_vld_d  = 1'b1;
            beat_mask_d = mask_cleared;
            if ((mask_cleared == 4'd0) && !beat_last_q) begin
                beat_vld_d = 1'b0;
            end
        end else if (!pend_vld_q && beat_vld_q && mask_zero && beat_last_q) begin
            // Stream with no kept bytes at all: nothing to flag, drop it
            beat_vld_d = 1'b0;
        end

        // Acceptance only happens while the buffer is empty, so it never collides with the actions above
        if (i_tvalid && i_tready) begin
            beat_data_d = i_tdata;
            beat_mask_d = i_tkeep;
            beat_last_d = i_tlast;
            beat_vld_d  = 1'b1;
        end

        if (load_out) begin
            o_en_d = 1'b1;
        end else if (o_en_q && o_rdy) begin
            o_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_data_q <= 32'd0;
            beat_mask_q <= 4'd0;
            beat_last_q <= 1'b0;
            beat_vld_q  <= 1'b0;
            pend_q      <= 8'd0;
            pend_vld_q  <= 1'b0;
            o_data_q    <= 9'd0;
            o_en_q      <= 1'b0;
        end else begin
            beat_data_q <= beat_data_d;
            beat_mask_q <= beat_mask_d;
            beat_last_q <= beat_last_d;
            beat_vld_q  <= beat_vld_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            o_data_q    <= o_data_d;
            o_en_q      <= o_en_d;
        end
    end

endmodule

// File: tb/tb_axis_byte_unpacker.sv
// Directed bench for axis_byte_unpacker: drives hand-written beats and compares emitted words.
module tb_axis_byte_unpacker;

    logic        clk;
    logic        rstn;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] i_tdata;
    logic [3:0]  i_tkeep;
    logic        i_tlast;
    logic        o_rdy;
    logic        o_en;
    logic [8:0]  o_data;

    int n_chk = 0;
    int n_err = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    logic       bp_on = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_idx = 0;

    logic       hold_prev = 1'b0;
    logic [8:0] prev_data = 9'd0;

    axis_byte_unpacker dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .i_tdata  (i_tdata),
        .i_tkeep  (i_tkeep),
        .i_tlast  (i_tlast),
        .o_rdy    (o_rdy),
        .o_en     (o_en),
        .o_data   (o_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Downstream ready: always high, or cycling 1,0,0,1 during the backpressure test
    initial begin
        o_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                o_rdy  = bp_pat[bp_idx];
                bp_idx = (bp_idx + 1) % 4;
            end else begin
                o_rdy = 1'b1;
            end
        end
    end

    // Capture transfers and check that a stalled output holds
    always @(negedge clk) begin
        if (rstn && hold_prev) begin
            chk("hold", {23'd0, o_en, o_data}, {23'd0, 1'b1, prev_data});
        end
        hold_prev = rstn & o_en & ~o_rdy;
        prev_data = o_data;
        if (rstn && o_en && o_rdy) got_q.push_back(o_data);
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        @(posedge clk);
        #1;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tkeep  = k;
        i_tlast  = l;
        t = 0;
        @(negedge clk);
        while (!i_tready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!i_tready) chk("tready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_b%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        end
        chk({tag, "_idle_oen"}, {31'd0, o_en}, 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rstn     = 1'b0;
        i_tvalid = 1'b0;
        i_tdata  = 32'd0;
        i_tkeep  = 4'd0;
        i_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oen",    {31'd0, o_en},     32'd0);
        chk("rst_odata",  {23'd0, o_data},   32'd0);
        chk("rst_tready", {31'd0, i_tready}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_tready", {31'd0, i_tready}, 32'd1);

        send_beat(32'h44332211, 4'hF, 1'b1);
        exp_q = '{9'h011, 9'h022, 9'h033, 9'h144};
        check_stream("single");

        send_beat(32'h04030201, 4'hF, 1'b0);
        send_beat(32'h000000AA, 4'h1, 1'b1);
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h1AA};
        check_stream("twobeat");

        send_beat(32'hDDCCBBAA, 4'b1010, 1'b1);
        exp_q = '{9'h0BB, 9'h1DD};
        check_stream("sparse");

        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h00000000, 4'h0, 1'b1);
        exp_q = '{9'h044, 9'h033, 9'h022, 9'h111};
        check_stream("term");

        send_beat(32'h55667788, 4'h0, 1'b1);
        repeat (6) @(negedge clk);
        chk("empty_count",  got_q.size(), 32'd0);
        chk("empty_tready", {31'd0, i_tready}, 32'd1);
        got_q.delete();

        bp_on = 1'b1;
        send_beat(32'hA4A3A2A1, 4'hF, 1'b1);
        exp_q = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
        check_stream("bp");
        bp_on = 1'b0;
        repeat (2) @(posedge clk);

        fork
            send_beat(32'h44332211, 4'hF, 1'b1);
            begin
                int t;
                t = 0;
                while (got_q.size() < 2 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("mid_two_bytes", got_q.size(), 32'd2);
                rstn = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_oen",    {31'd0, o_en},     32'd0);
        chk("mid_rst_tready", {31'd0, i_tready}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_no_flag", got_q.size(), 32'd2);
        got_q.delete();

        send_beat(32'h000000EE, 4'h1, 1'b1);
        exp_q = '{9'h1EE};
        check_stream("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
